// File: rtl/date_pkg.sv
// Shared types, constants and BCD helpers for the calendar date counter.
// The DATE_LEAP_YEAR_EN build option is consumed by date_counter, not here.
package date_pkg;

  typedef logic [3:0] bcd_t;

  // Date digits packed most significant first: DD MM YY, one BCD digit each.
  typedef struct packed {
    bcd_t d1;
    bcd_t d0;
    bcd_t m1;
    bcd_t m0;
    bcd_t y1;
    bcd_t y0;
  } date_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [7:0] MONTH_JAN = 8'h01;
  localparam logic [7:0] MONTH_FEB = 8'h02;
  localparam logic [7:0] MONTH_APR = 8'h04;
  localparam logic [7:0] MONTH_JUN = 8'h06;
  localparam logic [7:0] MONTH_SEP = 8'h09;
  localparam logic [7:0] MONTH_NOV = 8'h11;
  localparam logic [7:0] MONTH_DEC = 8'h12;

  localparam logic [7:0] DAY_FIRST  = 8'h01;
  localparam logic [7:0] YEAR_LAST  = 8'h99;
  localparam logic [7:0] YEAR_FIRST = 8'h00;

  localparam bcd_t RST_DAY1   = 4'd0;
  localparam bcd_t RST_DAY0   = 4'd1;
  localparam bcd_t RST_MONTH1 = 4'd0;
  localparam bcd_t RST_MONTH0 = 4'd1;

  function automatic logic is_bcd(input bcd_t digit);
    return digit <= BCD_MAX;
  endfunction

  // Divisible-by-4 test on a two-digit BCD year; 00 counts as leap.
  function automatic logic is_leap(input bcd_t y1, input bcd_t y0);
    logic ones_even_set;
    logic ones_odd_set;
    ones_even_set = (y0 == 4'd0) || (y0 == 4'd4) || (y0 == 4'd8);
    ones_odd_set  = (y0 == 4'd2) || (y0 == 4'd6);
    return y1[0] ? ones_odd_set : ones_even_set;
  endfunction

  // Two-digit BCD increment; ones 9 carries into tens, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] val);
    logic [7:0] res;
    if (val == YEAR_LAST) begin
      res = YEAR_FIRST;
    end else if (val[3:0] == BCD_MAX) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/month_last_day.sv
// Combinational last-day-of-month lookup, returning the day as two BCD digits.
// Out-of-range month codes fall to 31; callers validate the month separately.
module month_last_day
  import date_pkg::*;
(
  input  bcd_t month1_i,
  input  bcd_t month0_i,
  input  logic leap_i,
  output bcd_t ld1_o,
  output bcd_t ld0_o
);

  logic [7:0] ld;

  // NOTE: every path assigns ld (default first), so no latch is inferred.
  always_comb begin
    ld = 8'h31;
    case ({month1_i, month0_i})
      MONTH_FEB: ld = leap_i ? 8'h29 : 8'h28;
      MONTH_APR,
      MONTH_JUN,
      MONTH_SEP,
      MONTH_NOV: ld = 8'h30;
      default:   ld = 8'h31;
    endcase
  end

  assign ld1_o = ld[7:4];
  assign ld0_o = ld[3:0];

endmodule

// File: rtl/date_counter.sv
// Registered BCD calendar (DD/MM/YY) advanced by day_inc, loadable via set_en.
// Build option: define DATE_LEAP_YEAR_EN to give February 29 days in leap years.
module date_counter
  import date_pkg::*;
#(
  parameter bcd_t INIT_YEAR1 = 4'd0,
  parameter bcd_t INIT_YEAR0 = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_inc,
  input  logic       set_en,
  input  logic [3:0] set_day1,
  input  logic [3:0] set_day0,
  input  logic [3:0] set_month1,
  input  logic [3:0] set_month0,
  input  logic [3:0] set_year1,
  input  logic [3:0] set_year0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic       year_carry,
  output logic       set_err
);

  localparam date_t RST_DATE = '{
    d1: RST_DAY1,   d0: RST_DAY0,
    m1: RST_MONTH1, m0: RST_MONTH0,
    y1: INIT_YEAR1, y0: INIT_YEAR0
  };

  date_t date_q, date_d;
  logic  year_carry_q, year_carry_d;
  logic  set_err_q, set_err_d;

  date_t set_date;
  logic  cur_leap, set_leap;
  bcd_t  cur_ld1, cur_ld0;
  bcd_t  set_ld1, set_ld0;
  logic  at_last_day;
  logic  digits_ok, month_ok, day_ok, set_valid;

  assign set_date = '{
    d1: set_day1,   d0: set_day0,
    m1: set_month1, m0: set_month0,
    y1: set_year1,  y0: set_year0
  };

`ifdef DATE_LEAP_YEAR_EN
  assign cur_leap = is_leap(date_q.y1, date_q.y0);
  assign set_leap = is_leap(set_year1, set_year0);
`else
  assign cur_leap = 1'b0;
  assign set_leap = 1'b0;
`endif

  month_last_day u_cur_ld (
    .month1_i (date_q.m1),
    .month0_i (date_q.m0),
    .leap_i   (cur_leap),
    .ld1_o    (cur_ld1),
    .ld0_o    (cur_ld0)
  );

  month_last_day u_set_ld (
    .month1_i (set_month1),
    .month0_i (set_month0),
    .leap_i   (set_leap),
    .ld1_o    (set_ld1),
    .ld0_o    (set_ld0)
  );

  assign at_last_day = ({date_q.d1, date_q.d0} == {cur_ld1, cur_ld0});

  // Range compares on packed BCD pairs are only meaningful once all digits are <= 9.
  assign digits_ok = is_bcd(set_day1)   && is_bcd(set_day0)   &&
                     is_bcd(set_month1) && is_bcd(set_month0) &&
                     is_bcd(set_year1)  && is_bcd(set_year0);
  assign month_ok  = ({set_month1, set_month0} >= MONTH_JAN) &&
                     ({set_month1, set_month0} <= MONTH_DEC);
  assign day_ok    = ({set_day1, set_day0} >= DAY_FIRST) &&
                     ({set_day1, set_day0} <= {set_ld1, set_ld0});
  assign set_valid = digits_ok && month_ok && day_ok;

  always_comb begin
    date_d       = date_q;
    year_carry_d = 1'b0;
    set_err_d    = 1'b0;
    if (set_en) begin
      // A load always consumes the cycle; a coincident day_inc is dropped.
      if (set_valid) begin
        date_d = set_date;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (day_inc) begin
      if (!at_last_day) begin
        {date_d.d1, date_d.d0} = bcd_inc2({date_q.d1, date_q.d0});
      end else begin
        date_d.d1 = RST_DAY1;
        date_d.d0 = RST_DAY0;
        if ({date_q.m1, date_q.m0} != MONTH_DEC) begin
          {date_d.m1, date_d.m0} = bcd_inc2({date_q.m1, date_q.m0});
        end else begin
          date_d.m1 = RST_MONTH1;
          date_d.m0 = RST_MONTH0;
          {date_d.y1, date_d.y0} = bcd_inc2({date_q.y1, date_q.y0});
          year_carry_d = ({date_q.y1, date_q.y0} == YEAR_LAST);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      date_q       <= RST_DATE;
      year_carry_q <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      date_q       <= date_d;
      year_carry_q <= year_carry_d;
      set_err_q    <= set_err_d;
    end
  end

  assign day1       = date_q.d1;
  assign day0       = date_q.d0;
  assign month1     = date_q.m1;
  assign month0     = date_q.m0;
  assign year1      = date_q.y1;
  assign year0      = date_q.y0;
  assign year_carry = year_carry_q;
  assign set_err    = set_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: expectations queued at drive time, checked after the edge.
// Leap-dependent expectations follow DATE_LEAP_YEAR_EN as the RTL does.
module tb_date_counter;

`ifdef DATE_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [23:0] date;
    logic        carry;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_inc = 1'b0;
  logic       set_en = 1'b0;
  logic [3:0] set_day1 = '0, set_day0 = '0, set_month1 = '0;
  logic [3:0] set_month0 = '0, set_year1 = '0, set_year0 = '0;
  logic [3:0] day1, day0, month1, month0, year1, year0;
  logic       year_carry, set_err;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  date_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .day_inc    (day_inc),
    .set_en     (set_en),
    .set_day1   (set_day1),
    .set_day0   (set_day0),
    .set_month1 (set_month1),
    .set_month0 (set_month0),
    .set_year1  (set_year1),
    .set_year0  (set_year0),
    .day1       (day1),
    .day0       (day0),
    .month1     (month1),
    .month0     (month0),
    .year1      (year1),
    .year0      (year0),
    .year_carry (year_carry),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Pop one expectation and compare date and the two pulse flags.
  task automatic sample();
    exp_t        e;
    logic [23:0] obs_date;
    logic [1:0]  obs_flags;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e         = sb_q.pop_front();
      obs_date  = {day1, day0, month1, month0, year1, year0};
      obs_flags = {year_carry, set_err};
      assert (obs_date === e.date) else begin
        failures++;
        $error("FAIL %s date observed=%h expected=%h", e.tag, obs_date, e.date);
      end
      checks++;
      assert (obs_flags === {e.carry, e.err}) else begin
        failures++;
        $error("FAIL %s carry/err observed=%b expected=%b", e.tag, obs_flags, {e.carry, e.err});
      end
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, queue the expectation, check after the edge.
  task automatic step(input string tag, input logic rstn, input logic inc, input logic set,
                      input logic [23:0] sval, input logic [23:0] exp_date,
                      input logic exp_carry, input logic exp_err);
    exp_t e;
    @(negedge clk);
    rst_n   = rstn;
    day_inc = inc;
    set_en  = set;
    {set_day1, set_day0, set_month1, set_month0, set_year1, set_year0} = sval;
    e.tag = tag; e.date = exp_date; e.carry = exp_carry; e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic load(input string tag, input logic [23:0] sval,
                      input logic [23:0] exp_date, input logic exp_err);
    step(tag, 1'b1, 1'b0, 1'b1, sval, exp_date, 1'b0, exp_err);
  endtask

  task automatic inc(input string tag, input logic [23:0] exp_date, input logic exp_carry);
    step(tag, 1'b1, 1'b1, 1'b0, 24'h0, exp_date, exp_carry, 1'b0);
  endtask

  task automatic idle(input string tag, input logic [23:0] exp_date);
    step(tag, 1'b1, 1'b0, 1'b0, 24'h0, exp_date, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset overrides a concurrent load and advance.
    step("reset_busy", 1'b0, 1'b1, 1'b1, 24'h100623, 24'h010100, 1'b0, 1'b0);
    idle("reset_hold", 24'h010100);

    load("load_3004", 24'h300423, 24'h300423, 1'b0);
    inc ("apr_end",   24'h010523, 1'b0);
    load("load_3101", 24'h310123, 24'h310123, 1'b0);
    inc ("jan_end",   24'h010223, 1'b0);
    load("load_0910", 24'h091023, 24'h091023, 1'b0);
    inc ("ones_carry", 24'h101023, 1'b0);
    inc ("back2back", 24'h111023, 1'b0);
    load("load_3006", 24'h300623, 24'h300623, 1'b0);
    inc ("jun_end",   24'h010723, 1'b0);
    load("load_3107", 24'h310723, 24'h310723, 1'b0);
    inc ("jul_end",   24'h010823, 1'b0);
    load("load_3009", 24'h300923, 24'h300923, 1'b0);
    inc ("sep_end",   24'h011023, 1'b0);

    load("load_3112", 24'h311299, 24'h311299, 1'b0);
    inc ("year_wrap", 24'h010100, 1'b1);
    idle("carry_drop", 24'h010100);
    load("load_3198", 24'h311298, 24'h311298, 1'b0);
    inc ("year_inc",  24'h010199, 1'b0);

    load("load_2802_24", 24'h280224, 24'h280224, 1'b0);
    inc ("feb_leap",     LEAP ? 24'h290224 : 24'h010324, 1'b0);
    load("load_2802_23", 24'h280223, 24'h280223, 1'b0);
    inc ("feb_common",   24'h010323, 1'b0);
    load("load_2902_24", 24'h290224, LEAP ? 24'h290224 : 24'h010323, ~LEAP);
    load("load_2902_00", 24'h290200, LEAP ? 24'h290200 : 24'h010323, ~LEAP);
    load("load_2902_23", 24'h290223, LEAP ? 24'h290200 : 24'h010323, 1'b1);

    load("load_050505", 24'h050505, 24'h050505, 1'b0);
    load("bad_3104",    24'h310423, 24'h050505, 1'b1);
    load("bad_month13", 24'h151323, 24'h050505, 1'b1);
    load("bad_digitA",  24'h1A0123, 24'h050505, 1'b1);
    load("bad_day00",   24'h000523, 24'h050505, 1'b1);
    load("bad_month00", 24'h150023, 24'h050505, 1'b1);
    load("bad_year_9A", 24'h15059A, 24'h050505, 1'b1);
    idle("err_drop",    24'h050505);

    // Load wins over a coincident advance, valid or not.
    step("set_and_inc",     1'b1, 1'b1, 1'b1, 24'h100623, 24'h100623, 1'b0, 1'b0);
    step("bad_set_and_inc", 1'b1, 1'b1, 1'b1, 24'h000523, 24'h100623, 1'b0, 1'b1);
    inc ("after_drop", 24'h110623, 1'b0);

    step("reset_mid", 1'b0, 1'b1, 1'b0, 24'h0, 24'h010100, 1'b0, 1'b0);
    inc ("post_reset", 24'h020100, 1'b0);

    @(negedge clk);
    day_inc = 1'b0;
    set_en  = 1'b0;
    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
